adder_tree_feeder: RTL

- Upstream driver for the 8-input, registered adder tree.
- Collects 8 operands serially over a valid/ready stream, presents them in parallel to the tree, and waits the tree latency.
- Captures the tree sum and returns it on a valid/ready result stream.
- Sits between the serial operand source and the adder tree top.

---
 rtl/adder_tree_pkg.sv | 18 +
 rtl/adder_tree_feeder_lat_cnt.sv | 31 +++
 rtl/adder_tree_feeder.sv | 99 +++++++++
 3 files changed

// File: rtl/adder_tree_pkg.sv
// Shared types and sizing helpers for the 8-input adder tree and its feeder.
package adder_tree_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        WAIT    = 2'd1,
        OUTPUT  = 2'd2
    } feeder_state_t;

    localparam int N_OPERANDS = 8;
    localparam int CNT_W      = $clog2(N_OPERANDS);

    // Three extra bits hold 8 x max operand without truncation.
    function automatic int sum_width(input int data_w);
        return data_w + 3;
    endfunction

endpackage

// File: rtl/adder_tree_feeder_lat_cnt.sv
// Loadable down-counter: done_o pulses while enabled and the count has reached zero.
module adder_tree_feeder_lat_cnt #(
    parameter int TREE_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic en_i,
    output logic done_o
);

    localparam int CW = 4;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = CW'(TREE_LAT);
        else if (en_i && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign done_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/adder_tree_feeder.sv
// Serial-to-parallel operand feeder for the 8-input adder tree; waits TREE_LAT and returns the sum.
// Optional running-sum cross-check of the tree enabled by ADDER_TREE_FEEDER_SELFCHECK_EN.
module adder_tree_feeder
    import adder_tree_pkg::*;
#(
    parameter int  DATA_W   = 16,
    parameter int  TREE_LAT = 1,
    localparam int SUM_W    = sum_width(DATA_W)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic [N_OPERANDS*DATA_W-1:0] op_bus,
    input  logic [SUM_W-1:0]           tree_sum,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SUM_W-1:0]           out_sum,
    output logic                       busy,
    output logic                       chk_err
);

    feeder_state_t                          state_q;
    logic [CNT_W-1:0]                       cnt_q;
    logic [N_OPERANDS-1:0][DATA_W-1:0]      ops_q;
    logic                                   out_valid_q;
    logic [SUM_W-1:0]                       out_sum_q;
    logic                                   accept, last_beat, lat_done, capture, result_taken;

    assign in_ready     = (state_q == COLLECT);
    assign accept       = in_valid && in_ready;
    assign last_beat    = accept && (cnt_q == CNT_W'(N_OPERANDS - 1));
    assign capture      = (state_q == WAIT) && lat_done;
    assign result_taken = (state_q == OUTPUT) && out_ready;

    adder_tree_feeder_lat_cnt #(.TREE_LAT(TREE_LAT)) u_lat_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (last_beat),
        .en_i   (state_q == WAIT),
        .done_o (lat_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            cnt_q       <= '0;
            ops_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
        end else begin
            case (state_q)
                COLLECT: if (accept) begin
                    // Unwritten slots keep the previous transaction's operands.
                    ops_q[cnt_q] <= in_data;
                    cnt_q        <= cnt_q + 1'b1;
                    if (last_beat) state_q <= WAIT;
                end
                WAIT: if (capture) begin
                    out_sum_q   <= tree_sum;
                    out_valid_q <= 1'b1;
                    state_q     <= OUTPUT;
                end
                OUTPUT: if (result_taken) begin
                    out_valid_q <= 1'b0;
                    state_q     <= COLLECT;
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign op_bus    = ops_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign busy      = !((state_q == COLLECT) && (cnt_q == '0));

`ifdef ADDER_TREE_FEEDER_SELFCHECK_EN
    logic [SUM_W-1:0] acc_q;
    logic             chk_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            chk_err_q <= 1'b0;
        end else begin
            if (accept)            acc_q <= acc_q + SUM_W'(in_data);
            else if (result_taken) acc_q <= '0;
            if (capture && tree_sum != acc_q) chk_err_q <= 1'b1;
        end
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule
